// File: rtl/serpent_pkg.sv
// Shared Serpent constants, S-box tables and the linear transform used by the round lanes.
package serpent_pkg;
  localparam int SERPENT_ROUNDS = 32;
  localparam int SUBKEYS        = 33;
  localparam int BLK_W          = 128;

  typedef logic [BLK_W-1:0] blk_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [3:0] SBOX [8][16] = '{
    '{4'h3, 4'h8, 4'hF, 4'h1, 4'hA, 4'h6, 4'h5, 4'hB, 4'hE, 4'hD, 4'h4, 4'h2, 4'h7, 4'h0, 4'h9, 4'hC},
    '{4'hF, 4'hC, 4'h2, 4'h7, 4'h9, 4'h0, 4'h5, 4'hA, 4'h1, 4'hB, 4'hE, 4'h8, 4'h6, 4'hD, 4'h3, 4'h4},
    '{4'h8, 4'h6, 4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hF, 4'hD, 4'h1, 4'hE, 4'h4, 4'h0, 4'hB, 4'h5, 4'h2},
    '{4'h0, 4'hF, 4'hB, 4'h8, 4'hC, 4'h9, 4'h6, 4'h3, 4'hD, 4'h1, 4'h2, 4'h4, 4'hA, 4'h7, 4'h5, 4'hE},
    '{4'h1, 4'hF, 4'h8, 4'h3, 4'hC, 4'h0, 4'hB, 4'h6, 4'h2, 4'h5, 4'h4, 4'hA, 4'h9, 4'hE, 4'h7, 4'hD},
    '{4'hF, 4'h5, 4'h2, 4'hB, 4'h4, 4'hA, 4'h9, 4'hC, 4'h0, 4'h3, 4'hE, 4'h8, 4'hD, 4'h6, 4'h7, 4'h1},
    '{4'h7, 4'h2, 4'hC, 4'h5, 4'h8, 4'h4, 4'h6, 4'hB, 4'hE, 4'h9, 4'h1, 4'hF, 4'hD, 4'h3, 4'hA, 4'h0},
    '{4'h1, 4'hD, 4'hF, 4'h0, 4'hE, 4'h8, 4'h2, 4'hB, 4'h7, 4'h4, 4'hC, 4'hA, 4'h9, 4'h3, 4'h5, 4'h6}
  };

  function automatic logic [2:0] sbox_sel(input logic [4:0] round);
    return round[2:0];
  endfunction

  // Bitslice form: nibble i gathers bit i of each 32-bit word, x0 in the LSB.
  function automatic blk_t sbox_layer(input logic [2:0] sel, input blk_t x);
    blk_t       y;
    logic [3:0] n, o;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      n = {x[96+i], x[64+i], x[32+i], x[i]};
      o = SBOX[sel][n];
      y[i]    = o[0];
      y[32+i] = o[1];
      y[64+i] = o[2];
      y[96+i] = o[3];
    end
    return y;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic blk_t lin_trans(input blk_t x);
    logic [31:0] x0, x1, x2, x3;
    x0 = x[31:0];
    x1 = x[63:32];
    x2 = x[95:64];
    x3 = x[127:96];
    x0 = rotl(x0, 13);
    x2 = rotl(x2, 3);
    x1 = x1 ^ x0 ^ x2;
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rotl(x1, 1);
    x3 = rotl(x3, 7);
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rotl(x0, 5);
    x2 = rotl(x2, 22);
    return {x3, x2, x1, x0};
  endfunction
endpackage

// File: rtl/serpent_round_lane.sv
// One combinational Serpent round: key mix, S-box layer, then LT or the final key whitening.
module serpent_round_lane
  import serpent_pkg::*;
#(
  parameter int FIXED_SEL = -1
) (
  input  blk_t       x,
  input  logic [4:0] rnd,
  input  blk_t       k_r,
  input  blk_t       k_last,
  output blk_t       y
);
  logic [2:0] sel;
  blk_t       s;

  // A lane whose round is always the same modulo 8 hard-wires its S-box.
  if (FIXED_SEL >= 0) begin : g_fixed
    assign sel = 3'(FIXED_SEL);
  end else begin : g_mux
    assign sel = sbox_sel(rnd);
  end

  always_comb begin
    s = sbox_layer(sel, x ^ k_r);
    y = (rnd == 5'd31) ? (s ^ k_last) : lin_trans(s);
  end
endmodule

// File: rtl/serpent_enc_iterative.sv
// Iterative Serpent-256 encryptor: UNROLL chained round lanes reused over 32/UNROLL clocks per block.
module serpent_enc_iterative
  import serpent_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SUBKEYS*BLK_W-1:0] subkeys_flat,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BLK_W-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BLK_W-1:0]         out_data,
  output logic                     busy
);
  localparam int NSTEP = SERPENT_ROUNDS / UNROLL;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  if (!(UNROLL inside {1, 2, 4, 8, 16, 32})) begin : g_bad_unroll
    $error("serpent_enc_iterative: UNROLL must be 1, 2, 4, 8, 16 or 32");
  end

  state_t        state;
  logic [CW-1:0] cnt;
  blk_t          blk;
  blk_t          dout;
  logic          started;
  logic          accept;

  blk_t       chain [UNROLL+1];
  logic [4:0] rnd   [UNROLL];
  blk_t       key   [UNROLL];

  assign chain[0] = blk;

  for (genvar k = 0; k < UNROLL; k++) begin : g_lane
    assign rnd[k] = 5'((int'(cnt) * UNROLL) + k);
    assign key[k] = subkeys_flat[BLK_W*rnd[k] +: BLK_W];
    serpent_round_lane #(
      .FIXED_SEL((UNROLL >= 8) ? (k % 8) : -1)
    ) u_lane (
      .x     (chain[k]),
      .rnd   (rnd[k]),
      .k_r   (key[k]),
      .k_last(subkeys_flat[BLK_W*32 +: BLK_W]),
      .y     (chain[k+1])
    );
  end

  // started keeps in_ready low until the first edge after reset release.
  assign in_ready  = started & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out_data  = dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      blk     <= '0;
      dout    <= '0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            blk   <= in_data;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          blk <= chain[UNROLL];
          if (cnt == CW'(NSTEP - 1)) begin
            cnt   <= '0;
            dout  <= chain[UNROLL];
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          // Reloading straight from DONE keeps back-to-back blocks bubble-free.
          if (accept) begin
            blk   <= in_data;
            cnt   <= '0;
            state <= ST_RUN;
          end else if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
